// File: rtl/atm_pkg.sv
// Shared types for the ATM controller: FSM states, transaction codes and strobe edge helper.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAPT_PIN  = 3'd1,
    CHECK_PIN = 3'd2,
    SESION    = 3'd3,
    BLOQUEO   = 3'd4
  } state_t;

  localparam logic [1:0] TRANS_DEPOSITO = 2'd0;
  localparam logic [1:0] TRANS_RETIRO   = 2'd1;
  localparam logic [1:0] TRANS_CONSULTA = 2'd2;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/atm_pin_capture.sv
// PIN digit capture: digit strobe edge detect, shift register and digit counter.
// clr empties the register and counter; the strobe history survives clr so a held strobe never re-fires.
module atm_pin_capture
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          digit_stb,
  input  logic [PIN_DIGITS*DIGIT_W-1:0] pin_ref,
  output logic                          done,
  output logic                          match
);

  localparam int PIN_W = PIN_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);

  logic [PIN_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stb_prev;

  assign done  = (cnt_q == CNT_W'(PIN_DIGITS));
  assign match = (shift_q == pin_ref);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      stb_prev <= 1'b0;
    end else begin
      stb_prev <= digit_stb;
      if (clr) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (en && rise(digit_stb, stb_prev) && !done) begin
        shift_q <= (shift_q << DIGIT_W) | PIN_W'(digit);
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_ctrl_param.sv
// Parametrised ATM session controller: PIN check with retry/lockout, then repeated transactions.
// Optional build macro LIMITE_SESION_EN adds a cumulative per-session withdrawal cap.
//
// state     | meaning
// IDLE      | no card; waiting for tarjetaRecibida
// CAPT_PIN  | collecting PIN digits
// CHECK_PIN | one-cycle compare of entered PIN against card PIN
// SESION    | authenticated; serving transactions
// BLOQUEO   | locked out; only rst leaves
module atm_ctrl_param
  import atm_pkg::*;
#(
  parameter int             PIN_DIGITS    = 4,
  parameter int             DIGIT_W       = 4,
  parameter int             BAL_W         = 64,
  parameter int             MONTO_W       = 32,
  parameter int             MAX_INTENTOS  = 3,
  parameter logic [BAL_W-1:0] LIMITE_RETIRO = BAL_W'(100000)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tarjetaRecibida,
  input  logic [PIN_DIGITS*DIGIT_W-1:0] pinTarjeta,
  input  logic [DIGIT_W-1:0]            digito,
  input  logic                          digitoSTB,
  input  logic [1:0]                    tipoTrans,
  input  logic                          montoSTB,
  input  logic [MONTO_W-1:0]            monto,
  input  logic [BAL_W-1:0]              balanceInicial,
  output logic [BAL_W-1:0]              balance,
  output logic                          balanceActualizado,
  output logic                          entregarDinero,
  output logic                          fondosInsuficientes,
  output logic                          pinIncorrecto,
  output logic                          advertencia,
  output logic                          alarmaBloqueo,
  output logic                          limiteExcedido
);

  localparam int ATT_W = $clog2(MAX_INTENTOS + 1);

  // A zero cap would refuse every withdrawal, so treat it as a configuration error too.
  if (MONTO_W > BAL_W || PIN_DIGITS < 1 || MAX_INTENTOS < 2 || LIMITE_RETIRO == '0) begin : g_cfg_err
    $error("atm_ctrl_param: invalid parameter set");
  end

  state_t           state, state_next;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [ATT_W-1:0] att_q, att_d, att_inc;
  logic             adv_q, adv_d;
  logic             act_d, ent_d, fondos_d, pin_d;
  logic             monto_prev, monto_rise;
  logic             pin_done, pin_match;
  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   suma;

  assign monto_rise = rise(montoSTB, monto_prev);
  assign monto_ext  = BAL_W'(monto);
  assign suma       = {1'b0, bal_q} + {1'b0, monto_ext};
  assign att_inc    = att_q + 1'b1;

`ifdef LIMITE_SESION_EN
  logic [BAL_W-1:0] ret_q, ret_d;
  logic [BAL_W:0]   ret_sum;
  logic             lim_hit, lim_d, lim_q;

  assign ret_sum        = {1'b0, ret_q} + {1'b0, monto_ext};
  assign lim_hit        = ret_sum > {1'b0, LIMITE_RETIRO};
  assign limiteExcedido = lim_q;
`else
  assign limiteExcedido = 1'b0;
`endif

  atm_pin_capture #(
    .PIN_DIGITS (PIN_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_pin (
    .clk       (clk),
    .rst       (rst),
    .clr       (state != CAPT_PIN),
    .en        ((state == CAPT_PIN) && tarjetaRecibida),
    .digit     (digito),
    .digit_stb (digitoSTB),
    .pin_ref   (pinTarjeta),
    .done      (pin_done),
    .match     (pin_match)
  );

  always_comb begin
    state_next = state;
    bal_d      = bal_q;
    att_d      = att_q;
    adv_d      = adv_q;
    act_d      = 1'b0;
    ent_d      = 1'b0;
    fondos_d   = 1'b0;
    pin_d      = 1'b0;
`ifdef LIMITE_SESION_EN
    ret_d      = ret_q;
    lim_d      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (tarjetaRecibida) state_next = CAPT_PIN;
      end
      CAPT_PIN: begin
        if (!tarjetaRecibida) state_next = IDLE;
        else if (pin_done)    state_next = CHECK_PIN;
      end
      CHECK_PIN: begin
        if (!tarjetaRecibida) begin
          state_next = IDLE;
        end else if (pin_match) begin
          state_next = SESION;
          bal_d      = balanceInicial;
          att_d      = '0;
          adv_d      = 1'b0;
`ifdef LIMITE_SESION_EN
          ret_d      = '0;
`endif
        end else begin
          pin_d = 1'b1;
          att_d = att_inc;
          if (att_inc == ATT_W'(MAX_INTENTOS - 1)) adv_d = 1'b1;
          state_next = (att_inc == ATT_W'(MAX_INTENTOS)) ? BLOQUEO : CAPT_PIN;
        end
      end
      SESION: begin
        if (!tarjetaRecibida) begin
          state_next = IDLE;
        end else if (monto_rise) begin
          case (tipoTrans)
            TRANS_DEPOSITO: begin
              bal_d = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
              act_d = 1'b1;
            end
            TRANS_RETIRO: begin
`ifdef LIMITE_SESION_EN
              if (lim_hit) lim_d = 1'b1;
              else
`endif
              if (monto_ext <= bal_q) begin
                bal_d = bal_q - monto_ext;
                act_d = 1'b1;
                ent_d = 1'b1;
`ifdef LIMITE_SESION_EN
                ret_d = ret_sum[BAL_W-1:0];
`endif
              end else begin
                fondos_d = 1'b1;
              end
            end
            TRANS_CONSULTA: act_d = 1'b1;
            default: ;
          endcase
        end
      end
      BLOQUEO: ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      bal_q               <= '0;
      att_q               <= '0;
      adv_q               <= 1'b0;
      monto_prev          <= 1'b0;
      balanceActualizado  <= 1'b0;
      entregarDinero      <= 1'b0;
      fondosInsuficientes <= 1'b0;
      pinIncorrecto       <= 1'b0;
`ifdef LIMITE_SESION_EN
      ret_q               <= '0;
      lim_q               <= 1'b0;
`endif
    end else begin
      state               <= state_next;
      bal_q               <= bal_d;
      att_q               <= att_d;
      adv_q               <= adv_d;
      monto_prev          <= montoSTB;
      balanceActualizado  <= act_d;
      entregarDinero      <= ent_d;
      fondosInsuficientes <= fondos_d;
      pinIncorrecto       <= pin_d;
`ifdef LIMITE_SESION_EN
      ret_q               <= ret_d;
      lim_q               <= lim_d;
`endif
    end
  end

  assign balance       = bal_q;
  assign advertencia   = adv_q;
  assign alarmaBloqueo = (state == BLOQUEO);

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Directed self-checking bench for atm_ctrl_param; the cap scenario runs only when LIMITE_SESION_EN is defined.
module tb_atm_ctrl_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        tarjetaRecibida;
  logic [15:0] pinTarjeta;
  logic [3:0]  digito;
  logic        digitoSTB;
  logic [1:0]  tipoTrans;
  logic        montoSTB;
  logic [31:0] monto;
  logic [63:0] balanceInicial;
  logic [63:0] balance;
  logic        balanceActualizado, entregarDinero, fondosInsuficientes;
  logic        pinIncorrecto, advertencia, alarmaBloqueo, limiteExcedido;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  atm_ctrl_param #(
    .PIN_DIGITS   (4),
    .DIGIT_W      (4),
    .BAL_W        (64),
    .MONTO_W      (32),
    .MAX_INTENTOS (3)
`ifdef LIMITE_SESION_EN
    , .LIMITE_RETIRO (64'd30000)
`endif
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tarjetaRecibida     (tarjetaRecibida),
    .pinTarjeta          (pinTarjeta),
    .digito              (digito),
    .digitoSTB           (digitoSTB),
    .tipoTrans           (tipoTrans),
    .montoSTB            (montoSTB),
    .monto               (monto),
    .balanceInicial      (balanceInicial),
    .balance             (balance),
    .balanceActualizado  (balanceActualizado),
    .entregarDinero      (entregarDinero),
    .fondosInsuficientes (fondosInsuficientes),
    .pinIncorrecto       (pinIncorrecto),
    .advertencia         (advertencia),
    .alarmaBloqueo       (alarmaBloqueo),
    .limiteExcedido      (limiteExcedido)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic digit(input logic [3:0] d);
    digito    = d;
    digitoSTB = 1'b1;
    tick();
    digitoSTB = 1'b0;
    tick();
  endtask

  // Ends right after the CHECK_PIN cycle, so pinIncorrecto is visible on return.
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) digit(p[15-4*i -: 4]);
    tick();
  endtask

  task automatic trans(input logic [1:0] t, input logic [31:0] m);
    tipoTrans = t;
    monto     = m;
    montoSTB  = 1'b1;
    tick();
  endtask

  task automatic release_stb();
    montoSTB = 1'b0;
    tick();
  endtask

  task automatic new_session(input logic [63:0] bal0);
    tarjetaRecibida = 1'b0;
    tick();
    tarjetaRecibida = 1'b1;
    balanceInicial  = bal0;
    tick();
    enter_pin(16'hB6E9);
  endtask

  initial begin
    rst = 1'b1; tarjetaRecibida = 1'b0; pinTarjeta = 16'hB6E9; digito = '0; digitoSTB = 1'b0;
    tipoTrans = 2'd0; montoSTB = 1'b0; monto = '0; balanceInicial = 64'd50000;
    tick(); tick();
    chk("rst_balance", balance, 64'd0);
    chk("rst_alarm", alarmaBloqueo, 1'b0);
    chk("rst_adv", advertencia, 1'b0);
    chk("rst_pin", pinIncorrecto, 1'b0);
    rst = 1'b0;

    // 1: correct PIN then deposit
    tarjetaRecibida = 1'b1; tick();
    enter_pin(16'hB6E9);
    chk("t1_pin_ok", pinIncorrecto, 1'b0);
    chk("t1_bal_load", balance, 64'd50000);
    trans(2'd0, 32'd20000);
    chk("t1_dep_bal", balance, 64'd70000);
    chk("t1_dep_act", balanceActualizado, 1'b1);
    chk("t1_dep_noent", entregarDinero, 1'b0);
    release_stb();
    chk("t1_act_pulse", balanceActualizado, 1'b0);

    // 2: withdrawals
    new_session(64'd50000);
    chk("t2_bal_load", balance, 64'd50000);
    trans(2'd1, 32'd70000);
    chk("t2_nsf", fondosInsuficientes, 1'b1);
    chk("t2_nsf_bal", balance, 64'd50000);
    chk("t2_nsf_noent", entregarDinero, 1'b0);
    release_stb();
    trans(2'd1, 32'd20000);
    chk("t2_wd_ent", entregarDinero, 1'b1);
    chk("t2_wd_act", balanceActualizado, 1'b1);
    chk("t2_wd_bal", balance, 64'd30000);
    chk("t2_wd_nolim", limiteExcedido, 1'b0);
    release_stb();
    chk("t2_ent_pulse", entregarDinero, 1'b0);
    trans(2'd1, 32'd30000);
    chk("t2_wd_all", balance, 64'd0);
    chk("t2_wd_all_ent", entregarDinero, 1'b1);
    release_stb();
    trans(2'd3, 32'd5);
    chk("t2_rsv_act", balanceActualizado, 1'b0);
    chk("t2_rsv_bal", balance, 64'd0);
    release_stb();
    trans(2'd2, 32'd5);
    chk("t2_qry_act", balanceActualizado, 1'b1);
    chk("t2_qry_bal", balance, 64'd0);
    release_stb();

    // 3: lockout
    rst = 1'b1; tick(); rst = 1'b0;
    tarjetaRecibida = 1'b1; tick();
    enter_pin(16'h0000);
    chk("t3_pin1", pinIncorrecto, 1'b1);
    chk("t3_adv1", advertencia, 1'b0);
    enter_pin(16'h0000);
    chk("t3_pin2", pinIncorrecto, 1'b1);
    chk("t3_adv2", advertencia, 1'b1);
    chk("t3_alarm2", alarmaBloqueo, 1'b0);
    enter_pin(16'h0000);
    chk("t3_pin3", pinIncorrecto, 1'b1);
    chk("t3_alarm3", alarmaBloqueo, 1'b1);
    tarjetaRecibida = 1'b0; tick(); tarjetaRecibida = 1'b1;
    enter_pin(16'hB6E9);
    trans(2'd0, 32'd100);
    chk("t3_lock_alarm", alarmaBloqueo, 1'b1);
    chk("t3_lock_bal", balance, 64'd0);
    chk("t3_lock_act", balanceActualizado, 1'b0);
    release_stb();
    rst = 1'b1; tick();
    chk("t3_rst_alarm", alarmaBloqueo, 1'b0);
    chk("t3_rst_adv", advertencia, 1'b0);
    rst = 1'b0;

    // 4: warning persists across removal; partial PIN discarded on removal
    tarjetaRecibida = 1'b1; balanceInicial = 64'd50000; tick();
    enter_pin(16'h0000);
    enter_pin(16'h0000);
    chk("t4_adv", advertencia, 1'b1);
    tarjetaRecibida = 1'b0; tick();
    chk("t4_adv_persist", advertencia, 1'b1);
    tarjetaRecibida = 1'b1; tick();
    enter_pin(16'hB6E9);
    chk("t4_adv_drop", advertencia, 1'b0);
    chk("t4_bal", balance, 64'd50000);
    tarjetaRecibida = 1'b0; tick();
    tarjetaRecibida = 1'b1; tick();
    digit(4'hB); digit(4'h6);
    tarjetaRecibida = 1'b0; tick();
    tarjetaRecibida = 1'b1; balanceInicial = 64'd12345; tick();
    enter_pin(16'hB6E9);
    chk("t4_partial_pin", pinIncorrecto, 1'b0);
    chk("t4_partial_bal", balance, 64'd12345);

    // 5: saturation and held digit strobe
    new_session(64'hFFFF_FFFF_FFFF_FFFA);
    trans(2'd0, 32'd10);
    chk("t5_sat", balance, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t5_sat_act", balanceActualizado, 1'b1);
    release_stb();
    tarjetaRecibida = 1'b0; tick();
    tarjetaRecibida = 1'b1; balanceInicial = 64'd777; tick();
    digito = 4'hB; digitoSTB = 1'b1;
    repeat (5) tick();
    digitoSTB = 1'b0; tick();
    digit(4'h6); digit(4'hE); digit(4'h9);
    tick();
    chk("t5_held_pin", pinIncorrecto, 1'b0);
    chk("t5_held_bal", balance, 64'd777);
    digitoSTB = 1'b1; digito = 4'h1;
    trans(2'd0, 32'd5);
    chk("t5_both_stb", balance, 64'd782);
    digitoSTB = 1'b0;
    release_stb();

`ifdef LIMITE_SESION_EN
    // 6: session withdrawal cap
    new_session(64'd50000);
    trans(2'd1, 32'd20000);
    chk("t6_wd_ok", entregarDinero, 1'b1);
    chk("t6_wd_bal", balance, 64'd30000);
    release_stb();
    trans(2'd1, 32'd15000);
    chk("t6_lim", limiteExcedido, 1'b1);
    chk("t6_lim_noent", entregarDinero, 1'b0);
    chk("t6_lim_nonsf", fondosInsuficientes, 1'b0);
    chk("t6_lim_bal", balance, 64'd30000);
    release_stb();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/atm_ctrl_param.md
Name: atm_ctrl_param

Overview:
Parametrised successor to the single-session ATM controller. Captures a PIN of configurable length digit by digit, with retry counting, warning and lockout. After a correct PIN it serves any number of deposit, withdrawal or balance-query transactions per card session against an internally held balance. Sits between the keypad/card-reader front end and the cash dispenser/account interface.

Parameters:
PIN_DIGITS, 4, number of PIN digits per attempt (>=1)
DIGIT_W, 4, width of one PIN digit
BAL_W, 64, balance width
MONTO_W, 32, amount width (MONTO_W <= BAL_W)
MAX_INTENTOS, 3, wrong attempts before lockout (>=2)
LIMITE_RETIRO, 100000, session withdrawal cap; used only with LIMITE_SESION_EN

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
tarjetaRecibida  in  1  card present (level)
pinTarjeta  in  PIN_DIGITS*DIGIT_W  stored PIN; MS digit is entered first
digito  in  DIGIT_W  keypad digit
digitoSTB  in  1  digit strobe
tipoTrans  in  2  transaction type: 0 deposit, 1 withdraw, 2 query, 3 reserved
montoSTB  in  1  amount/transaction strobe
monto  in  MONTO_W  amount
balanceInicial  in  BAL_W  account balance, loaded on PIN success
balance  out  BAL_W  current session balance
balanceActualizado  out  1  one-cycle pulse: balance changed or query served
entregarDinero  out  1  one-cycle pulse: dispense monto
fondosInsuficientes  out  1  one-cycle pulse: withdrawal rejected
pinIncorrecto  out  1  one-cycle pulse per wrong PIN
advertencia  out  1  level: exactly one attempt left
alarmaBloqueo  out  1  level: locked
limiteExcedido  out  1  one-cycle pulse (tied 0 without macro)

Behaviour:
- Reset (rst=1 at edge): state IDLE, all outputs 0, balance 0, digit count 0, attempt count 0. Reset has priority over every event, including lockout.
- Strobes are rising-edge detected. Registered previous-sample flops are cleared by reset. A strobe held high counts once.
- Response outputs appear one cycle after the edge that samples the strobe rise.
- States: IDLE, CAPT_PIN, CHECK_PIN, SESION, BLOQUEO.
- IDLE -> CAPT_PIN when tarjetaRecibida=1; digit count cleared.
- CAPT_PIN: each digitoSTB rise shifts digito into the PIN register. Count reaches PIN_DIGITS -> CHECK_PIN.
- CHECK_PIN, single cycle:
  - match -> SESION; balance<=balanceInicial; attempts<=0; advertencia<=0.
  - mismatch -> pinIncorrecto pulse; attempts+1.
    - attempts+1 == MAX_INTENTOS-1 -> advertencia<=1.
    - attempts+1 == MAX_INTENTOS -> BLOQUEO; otherwise back to CAPT_PIN.
- SESION, on montoSTB rise, monto zero-extended to BAL_W:
  - deposit: balance+=monto, saturating at all-ones; balanceActualizado pulse.
  - withdraw, monto<=balance: balance-=monto; balanceActualizado and entregarDinero pulse together.
  - withdraw, monto>balance: fondosInsuficientes pulse; balance unchanged.
  - withdraw of exactly the balance is allowed, giving balance 0.
  - query: balanceActualizado pulse only.
  - reserved code (3): ignored, no pulse.
  - State stays SESION after every transaction, allowing multiple transactions.
- tarjetaRecibida=0 in CAPT_PIN, CHECK_PIN or SESION -> IDLE next cycle.
  - Digit count and partial PIN are cleared. Balance is held for observation.
  - Attempt count and advertencia persist across card removal.
- BLOQUEO: alarmaBloqueo=1; all strobes and the card input are ignored; exit only by rst.
- Simultaneous digitoSTB and montoSTB rises: only the strobe relevant to the current state acts.

Optional Feature:
LIMITE_SESION_EN
- Defined: a cumulative withdrawn-amount register is cleared on entry to SESION.
  - If a withdrawal would push the total above LIMITE_RETIRO, limiteExcedido pulses, no dispense occurs and balance is unchanged.
  - The limit check takes priority over the funds check.
- Undefined: no register is built; limiteExcedido is tied to 0.

Decomposition:
- Package atm_pkg holds:
  - state enum;
  - tipoTrans codes TRANS_DEPOSITO, TRANS_RETIRO, TRANS_CONSULTA;
  - a rising-edge helper function.
- Sub-module atm_pin_capture: edge detect on digitoSTB, shift register, digit counter, and done/match outputs with a clear input.

Test Plan:
1. rst; card; PIN 0xB6E9 entered as B,6,E,9; balanceInicial=50000; deposit 20000 -> balance=70000, one balanceActualizado pulse, no entregarDinero.
2. Correct PIN, balance 50000:
   - withdraw 70000 -> fondosInsuficientes, balance 50000;
   - withdraw 20000 -> entregarDinero + balanceActualizado, balance 30000;
   - withdraw 30000 -> balance 0.
3. Three wrong PINs (0000) -> three pinIncorrecto pulses; advertencia after the 2nd; alarmaBloqueo after the 3rd. Further strobes change nothing; rst clears all.
4. Two wrong PINs, card removed, reinserted, correct PIN -> SESION, advertencia drops; card removed after 2 digits -> IDLE, digit count 0.
5. Balance all-ones minus 5, deposit 10 -> balance all-ones (saturated); digitoSTB held high 5 cycles -> one digit captured.
6. With LIMITE_SESION_EN, LIMITE_RETIRO=30000, balance 50000: withdraw 20000 succeeds; withdraw 15000 -> limiteExcedido, balance 30000.
